io_buf_2_ctrl: RTL and testbench

IO_BUF_2_CTRL -- requirements
Module: io_buf_2_ctrl

---
 rtl/io_buf_2_ctrl.sv | 164 ++++++++++++++++
 tb/tb_io_buf_2_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/io_buf_2_ctrl.sv
// Purpose: runs one write/readback sequence on a 2-bit IO buffer, then compares the readback with the written value.
// Latency: a start accepted in IDLE leads to a done pulse T_SETUP+T_WR+T_HOLD+T_RLS+T_RD+1 cycles later.
// Backpressure: none. start is sampled only in IDLE and ignored while a transaction is running.
module io_buf_2_ctrl #(
   parameter int unsigned T_SETUP = 2,
   parameter int unsigned T_WR    = 2,
   parameter int unsigned T_HOLD  = 2,
   parameter int unsigned T_RLS   = 1,
   parameter int unsigned T_RD    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] data_in,
   input  logic [1:0] rd_data,
   output logic       in1,
   output logic       in2,
   output logic       wr_en,
   output logic       rd_en,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic       fail,
   output logic [3:0] led
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_WRITE,
      S_HOLD,
      S_RELEASE,
      S_READ,
      S_DONE
   } state_t;

   // Phase lengths as counter load values (each phase length is 1..255).
   localparam logic [7:0] C_SETUP = 8'(T_SETUP);
   localparam logic [7:0] C_WR    = 8'(T_WR);
   localparam logic [7:0] C_HOLD  = 8'(T_HOLD);
   localparam logic [7:0] C_RLS   = 8'(T_RLS);
   localparam logic [7:0] C_RD    = 8'(T_RD);

   state_t     state_q;
   logic [7:0] cnt_q;
   logic [1:0] wdata_q;
   logic       in1_q;
   logic       in2_q;
   logic       wr_en_q;
   logic       rd_en_q;
   logic       busy_q;
   logic       done_q;
   logic       pass_q;
   logic       fail_q;
   logic [3:0] led_q;
   logic       cnt_last;

   // The current phase ends on the cycle where the down-counter reads 1.
   assign cnt_last = (cnt_q == 8'd1);

   // Sequencer FSM. Every output is a register that is updated on the same edge as the state,
   // so the outputs change together with the phase they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         wdata_q <= 2'b00;
         in1_q   <= 1'b0;
         in2_q   <= 1'b0;
         wr_en_q <= 1'b0;
         rd_en_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
         led_q   <= 4'b0000;
      end else begin
         done_q <= 1'b0;
         cnt_q  <= cnt_q - 8'd1;
         case (state_q)
            S_IDLE: begin
               cnt_q <= 8'd0;
               if (start) begin
                  wdata_q <= data_in;
                  pass_q  <= 1'b0;
                  fail_q  <= 1'b0;
                  led_q   <= 4'b0000;
                  busy_q  <= 1'b1;
                  cnt_q   <= C_SETUP;
                  state_q <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (cnt_last) begin
                  {in1_q, in2_q} <= wdata_q;
                  wr_en_q        <= 1'b1;
                  cnt_q          <= C_WR;
                  state_q        <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (cnt_last) begin
                  // Data stays on the pins through HOLD; only the strobe drops.
                  wr_en_q <= 1'b0;
                  cnt_q   <= C_HOLD;
                  state_q <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (cnt_last) begin
                  in1_q   <= 1'b0;
                  in2_q   <= 1'b0;
                  cnt_q   <= C_RLS;
                  state_q <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               if (cnt_last) begin
                  rd_en_q <= 1'b1;
                  cnt_q   <= C_RD;
                  state_q <= S_READ;
               end
            end
            S_READ: begin
               if (cnt_last) begin
                  // Readback is captured on the edge that leaves READ.
                  rd_en_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  led_q   <= 4'b0001 << rd_data;
                  pass_q  <= (rd_data == wdata_q);
                  fail_q  <= (rd_data != wdata_q);
                  cnt_q   <= 8'd0;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               cnt_q   <= 8'd0;
               state_q <= S_IDLE;
            end
            default: begin
               cnt_q   <= 8'd0;
               in1_q   <= 1'b0;
               in2_q   <= 1'b0;
               wr_en_q <= 1'b0;
               rd_en_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign in1   = in1_q;
   assign in2   = in2_q;
   assign wr_en = wr_en_q;
   assign rd_en = rd_en_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign pass  = pass_q;
   assign fail  = fail_q;
   assign led   = led_q;

endmodule

// File: tb/tb_io_buf_2_ctrl.sv
// Purpose: bench for io_buf_2_ctrl with default timing and with T_WR=1/T_RD=3, compared against a timeline model.
// Latency: outputs are checked 1 time unit after every rising edge.
// Backpressure: not applicable.
module tb_io_buf_2_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] data_in = 2'b00;
   logic [1:0] rdv [2];
   logic       in1_w [2];
   logic       in2_w [2];
   logic       wr_w [2];
   logic       rd_w [2];
   logic       busy_w [2];
   logic       done_w [2];
   logic       pass_w [2];
   logic       fail_w [2];
   logic [3:0] led_w [2];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Phase lengths per instance: setup, write, hold, release, read.
   int P [2][5] = '{'{2, 2, 2, 1, 1}, '{2, 1, 2, 1, 3}};

   // Reference model: whether a transaction is running and how many cycles since acceptance.
   bit         m_act [2];
   int         m_k [2];
   logic [1:0] m_wd [2];
   logic       m_pass [2];
   logic       m_fail [2];
   logic [3:0] m_led [2];
   int         m_acc [2];

   // readback source: 1 = echo the written value, 0 = use fval
   bit         tie = 1'b1;
   logic [1:0] fval = 2'b00;

   always #5 clk = ~clk;

   io_buf_2_ctrl dut0 (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in), .rd_data(rdv[0]),
      .in1(in1_w[0]), .in2(in2_w[0]), .wr_en(wr_w[0]), .rd_en(rd_w[0]),
      .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .fail(fail_w[0]), .led(led_w[0])
   );

   io_buf_2_ctrl #(.T_SETUP(2), .T_WR(1), .T_HOLD(2), .T_RLS(1), .T_RD(3)) dut1 (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in), .rd_data(rdv[1]),
      .in1(in1_w[1]), .in2(in2_w[1]), .wr_en(wr_w[1]), .rd_en(rd_w[1]),
      .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .fail(fail_w[1]), .led(led_w[1])
   );

   function automatic int busy_len(int i);
      return P[i][0] + P[i][1] + P[i][2] + P[i][3] + P[i][4];
   endfunction

   // Expected output vector derived from the position within the transaction timeline.
   function automatic logic [11:0] expect_out(int i);
      int  k, s, w, h, r, b;
      logic bz, dn, we, re, dv;
      k  = m_k[i];
      s  = P[i][0];
      w  = s + P[i][1];
      h  = w + P[i][2];
      r  = h + P[i][3];
      b  = busy_len(i);
      bz = m_act[i] && (k <= b);
      dn = m_act[i] && (k == b + 1);
      we = m_act[i] && (k > s) && (k <= w);
      dv = m_act[i] && (k > s) && (k <= h);
      re = m_act[i] && (k > r) && (k <= b);
      return {bz, dn, we, re, (dv ? m_wd[i] : 2'b00), m_pass[i], m_fail[i], m_led[i]};
   endfunction

   task automatic model_edge(int i);
      int b;
      b = busy_len(i);
      if (rst) begin
         m_act[i]  = 1'b0;
         m_k[i]    = 0;
         m_wd[i]   = 2'b00;
         m_pass[i] = 1'b0;
         m_fail[i] = 1'b0;
         m_led[i]  = 4'b0000;
      end else if (m_act[i]) begin
         if (m_k[i] == b) begin
            m_led[i]  = 4'b0001 << rdv[i];
            m_pass[i] = (rdv[i] == m_wd[i]);
            m_fail[i] = (rdv[i] != m_wd[i]);
         end
         if (m_k[i] == b + 1) m_act[i] = 1'b0;
         else m_k[i] = m_k[i] + 1;
      end else if (start) begin
         m_act[i]  = 1'b1;
         m_k[i]    = 1;
         m_wd[i]   = data_in;
         m_pass[i] = 1'b0;
         m_fail[i] = 1'b0;
         m_led[i]  = 4'b0000;
         m_acc[i]  = m_acc[i] + 1;
      end
   endtask

   task automatic check_inst(int i);
      logic [11:0] obs, exp;
      obs = {busy_w[i], done_w[i], wr_w[i], rd_w[i], in1_w[i], in2_w[i],
             pass_w[i], fail_w[i], led_w[i]};
      exp = expect_out(i);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL outputs inst%0d cyc%0d obs=%b exp=%b (busy,done,wr,rd,in1,in2,pass,fail,led)",
                i, cyc, obs, exp);
      end
   endtask

   // Drive readback, advance one clock edge, update the model with the inputs seen at that edge, then check.
   task automatic step();
      for (int i = 0; i < 2; i++) rdv[i] = tie ? m_wd[i] : fval;
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) model_edge(i);
      #1;
      for (int i = 0; i < 2; i++) check_inst(i);
   endtask

   task automatic run(int n);
      for (int j = 0; j < n; j++) step();
   endtask

   initial begin
      int seq [4];
      int base;
      int guard;
      seq = '{3, 2, 1, 0};
      for (int i = 0; i < 2; i++) begin
         m_act[i] = 1'b0; m_k[i] = 0; m_wd[i] = 2'b00;
         m_pass[i] = 1'b0; m_fail[i] = 1'b0; m_led[i] = 4'b0000; m_acc[i] = 0;
         rdv[i] = 2'b00;
      end

      // Reset state, with start high to show reset overrides it.
      rst = 1'b1; start = 1'b1;
      run(2);
      start = 1'b0;
      rst = 1'b0;
      run(1);

      // Write 3 with readback echoed: expect pass and led=1000.
      tie = 1'b1; data_in = 2'd3; start = 1'b1;
      step();
      start = 1'b0; data_in = 2'd0;
      run(14);

      // Write 1 with readback forced to 0: expect fail and led=0001.
      tie = 1'b0; fval = 2'b00; data_in = 2'd1; start = 1'b1;
      step();
      start = 1'b0;
      run(14);

      // Back-to-back 3,2,1,0 with start held high.
      tie = 1'b1; base = m_acc[0]; guard = 0;
      data_in = 2'(seq[0]); start = 1'b1;
      while ((m_acc[0] - base) < 4 && guard < 60) begin
         step();
         guard++;
         if ((m_acc[0] - base) < 4) data_in = 2'(seq[m_acc[0] - base]);
      end
      start = 1'b0;
      checks++;
      assert ((m_acc[0] - base) == 4) else begin
         errors++;
         $error("FAIL b2b_accepts obs=%0d exp=4", m_acc[0] - base);
      end
      run(14);

      // Start again with new data during WRITE: must be ignored.
      data_in = 2'd2; start = 1'b1;
      step();
      start = 1'b0;
      guard = 0;
      while (!(m_act[0] && m_k[0] == P[0][0] + 1) && guard < 20) begin step(); guard++; end
      data_in = 2'd1; start = 1'b1;
      step();
      start = 1'b0; data_in = 2'd3;
      run(14);

      // Reset during HOLD, then a normal transaction.
      data_in = 2'd2; start = 1'b1;
      step();
      start = 1'b0;
      guard = 0;
      while (!(m_act[0] && m_k[0] == P[0][0] + P[0][1] + 1) && guard < 20) begin step(); guard++; end
      rst = 1'b1;
      step();
      rst = 1'b0; data_in = 2'd1; start = 1'b1;
      step();
      start = 1'b0;
      run(14);

      // Randomized traffic.
      for (int j = 0; j < 400; j++) begin
         rst     = ($urandom_range(0, 59) == 0);
         start   = ($urandom_range(0, 3) == 0);
         data_in = 2'($urandom);
         tie     = ($urandom_range(0, 2) != 0);
         fval    = 2'($urandom);
         step();
      end
      rst = 1'b0; start = 1'b0;
      run(14);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
